serial_sub_ctrl: RTL

- Bit-serial N-bit unsigned subtractor controller. Computes A − B one bit per clock on a single 1-bit subtract cell, LSB first, and carries the borrow in a flip-flop between bits.
- The 1-bit cell is two half_subtractor instances plus an OR of their borrows.
- Sits between a requester issuing start/operands and the consumer of Diff/Borrow. Trades WIDTH cycles of latency for one-bit datapath area.

---
 rtl/serial_sub_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one half-subtractor pair per clock, LSB first, borrow held in a flop.
// Latency WIDTH cycles from accepted start to done; start is ignored (not queued) while RUN/DONE.

module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bo
);
   assign d  = a ^ b;
   assign bo = ~a & b;
endmodule

module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] r_sh_q, r_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;

   logic             d1, b1, d, b2, bout;
   logic             last_bit;
   logic [WIDTH-1:0] r_next;

   half_subtractor u_hs1 (.a(a_sh_q[0]), .b(b_sh_q[0]), .d(d1), .bo(b1));
   half_subtractor u_hs2 (.a(d1),        .b(bin_q),     .d(d),  .bo(b2));

   assign bout     = b1 | b2;
   assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   // New result bit enters at the MSB; written as shift/OR so WIDTH=1 needs no special case.
   assign r_next   = (r_sh_q >> 1) | (WIDTH'(d) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         r_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         r_sh_q   <= r_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      r_sh_d   = r_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d = A;
               b_sh_d = B;
               r_sh_d = '0;
               cnt_d  = '0;
               bin_d  = 1'b0;
            end
         end
         RUN: begin
            r_sh_d = r_next;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            bin_d  = bout;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
               diff_d   = r_next;
               borrow_d = bout;
               done_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy   = (state_q == RUN);
      done   = done_q;
      Diff   = diff_q;
      Borrow = borrow_q;
   end
endmodule
